serial_operand_tx: RTL and testbench
====================================

SERIAL_OPERAND_TX -- requirements
Module: serial_operand_tx

Interface
REQ-001 Parameter: DATA_W, default 8, operand width in bits; legal values are 2 and above.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: i_rst  input  1  synchronous, active-high reset.
REQ-004 Port: i_in_valid  input  1  operand pair offered.
REQ-005 Port: o_in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 Port: i_a  input  DATA_W  operand A, parallel.
REQ-007 Port: i_b  input  DATA_W  operand B, parallel.
REQ-008 Port: i_stall  input  1  downstream pause; freezes the serial stream.
REQ-009 Port: o_valid  output  1  serial bit valid; drives the multiplier chain's per-cycle enable.
REQ-010 Port: o_a  output  1  serial operand A bit, LSB first.
REQ-011 Port: o_b  output  1  serial operand B bit, LSB first.
REQ-012 Port: o_first  output  1  marks the bit-0 cycle of an operation.
REQ-013 Port: o_last  output  1  marks the final flush cycle of an operation.
REQ-014 Port: o_busy  output  1  high while the block is outside IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and FLUSH, plus a bit counter of width clog2(DATA_W).
REQ-016 An accept SHALL occur when i_in_valid and o_in_ready are both high at a rising edge; on accept, i_a and i_b are loaded into shift registers, the counter is cleared and the state moves to SHIFT.
REQ-017 o_in_ready SHALL be high in IDLE regardless of i_stall, and high in FLUSH when the counter equals DATA_W-1 and i_stall is low; it is low in every other case.
REQ-018 In SHIFT, o_a and o_b SHALL equal bit 0 of their respective shift registers.
REQ-019 Each non-stalled SHIFT cycle SHALL shift both registers right by one, filling with 0, and increment the counter.
REQ-020 A non-stalled SHIFT cycle with counter = DATA_W-1 SHALL clear the counter and move the state to FLUSH.
REQ-021 In FLUSH, o_a and o_b SHALL be 0 for DATA_W non-stalled cycles so the serial multiplier drains its carries and upper product bits.
REQ-022 A non-stalled FLUSH cycle with counter = DATA_W-1 SHALL move the state to SHIFT if an accept occurs on that same edge (back-to-back, no bubble), and to IDLE otherwise.
REQ-023 o_valid SHALL equal (state != IDLE) AND NOT i_stall.
REQ-024 In IDLE, o_a and o_b SHALL be 0.
REQ-025 While i_stall is high, the state, counter and shift registers SHALL hold their values, and o_a and o_b SHALL hold their current values.
REQ-026 o_first SHALL equal SHIFT AND counter = 0; o_last SHALL equal FLUSH AND counter = DATA_W-1; both are gated by NOT i_stall.
REQ-027 o_busy SHALL equal state != IDLE.
REQ-028 One operation SHALL take exactly 2*DATA_W o_valid cycles from the first o_valid to the last.
REQ-029 Latency SHALL be: accept edge, then the first o_valid in the next cycle when i_stall is low.

Reset
REQ-030 While i_rst is high at a rising edge, the block SHALL go to state IDLE with counter = 0 and both shift registers = 0.
REQ-031 After reset, the outputs SHALL be: o_valid = 0, o_a = 0, o_b = 0, o_first = 0, o_last = 0, o_busy = 0 and o_in_ready = 1.
REQ-032 A reset during SHIFT or FLUSH SHALL abandon the operation with no further o_valid; reset takes priority over i_stall and over an accept.

Verification
REQ-033 Basic case, DATA_W=8, a=0xB5, b=0x3C, no stall: o_a SHALL be 1,0,1,0,1,1,0,1 followed by 8 zeros; o_b SHALL be 0,0,1,1,1,1,0,0 followed by 8 zeros; o_first SHALL pulse on cycle 1, o_last on cycle 16, and o_valid SHALL be high for exactly 16 cycles.
REQ-034 Back-to-back case: a second pair is held valid during the first operation; it SHALL be accepted on the o_last cycle, giving 32 contiguous o_valid cycles and o_first on cycle 17.
REQ-035 Stall case: i_stall is high for 3 cycles during SHIFT bit 4; o_valid SHALL drop for those 3 cycles, o_a/o_b SHALL hold bit 4, and the bit sequence SHALL resume unchanged.
REQ-036 Stall on last cycle: i_stall is high on the FLUSH cycle with counter = 7 while i_in_valid is high; o_in_ready SHALL be 0 and no accept SHALL occur until i_stall falls.
REQ-037 Mid-operation reset: i_rst is pulsed at SHIFT bit 3; on the next cycle o_busy SHALL be 0, o_valid 0 and o_in_ready 1, and a new pair SHALL then serialize correctly from bit 0.
REQ-038 Edge values: a=0xFF with b=0xFF, and a=0x00 with b=0x00, SHALL each produce the correct all-ones or all-zeros SHIFT phase followed by 8 flush zeros.

Source files
------------

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand feeder for a bit-serial multiplier: streams two
// DATA_W-bit operands LSB first, then DATA_W zero cycles to flush the product.
module serial_operand_tx #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_stall,
    output logic              o_valid,
    output logic              o_a,
    output logic              o_b,
    output logic              o_first,
    output logic              o_last,
    output logic              o_busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] a_sr_r;
    logic [DATA_W-1:0] b_sr_r;

    logic              cnt_max_s;
    logic              in_ready_s;
    logic              accept_s;

    // Handshake: the last flush cycle doubles as the accept slot for the next pair.
    always_comb begin
        cnt_max_s  = (cnt_r == CNT_MAX);
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_FLUSH: in_ready_s = cnt_max_s && !i_stall;
            default:  in_ready_s = 1'b0;
        endcase
        accept_s = i_in_valid && in_ready_s;
    end

    // Sequencer: state, bit counter and operand shift registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_sr_r  <= {DATA_W{1'b0}};
            b_sr_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_sr_r  <= i_a;
                        b_sr_r  <= i_b;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!i_stall) begin
                        a_sr_r <= {1'b0, a_sr_r[DATA_W-1:1]};
                        b_sr_r <= {1'b0, b_sr_r[DATA_W-1:1]};
                        if (cnt_max_s) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_FLUSH;
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!i_stall) begin
                        if (cnt_max_s) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (accept_s) begin
                                a_sr_r  <= i_a;
                                b_sr_r  <= i_b;
                                state_r <= ST_SHIFT;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode; stall gates only the strobes, data bits follow the held state.
    always_comb begin
        o_in_ready = in_ready_s;
        o_busy     = (state_r != ST_IDLE);
        o_valid    = (state_r != ST_IDLE) && !i_stall;
        o_first    = (state_r == ST_SHIFT) && (cnt_r == {CNT_W{1'b0}}) && !i_stall;
        o_last     = (state_r == ST_FLUSH) && cnt_max_s && !i_stall;
        if (state_r == ST_SHIFT) begin
            o_a = a_sr_r[0];
            o_b = b_sr_r[0];
        end else begin
            o_a = 1'b0;
            o_b = 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: position-based reference model checked every
// cycle, plus literal expectations on the captured serial streams.
module tb_serial_operand_tx;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         stall = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic         in_ready, valid, sa, sb, first, last, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    serial_operand_tx #(.DATA_W(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a_in), .i_b(b_in), .i_stall(stall), .o_valid(valid),
        .o_a(sa), .o_b(sb), .o_first(first), .o_last(last), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an operation is a position 0..2N-1; operand bits for
    // positions below N, zeros afterwards. Stall freezes the position.
    logic         m_busy = 1'b0;
    int           m_pos = 0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;
    logic         m_ready;
    assign m_ready = !m_busy || (m_pos == 2*N-1 && !stall);

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1; m_pos <= 0; m_a <= a_in; m_b <= b_in;
            end
        end else if (!stall) begin
            if (m_pos == 2*N-1) begin
                if (in_valid) begin
                    m_pos <= 0; m_a <= a_in; m_b <= b_in;
                end else begin
                    m_busy <= 1'b0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // Per-cycle compare and stream capture on the falling edge.
    bit           chk_en = 1'b0;
    int           nbeats = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;
    logic [63:0]  beat_a = '0, beat_b = '0, first_mask = '0, last_mask = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 64'(in_ready), 64'(m_ready));
            chk("busy",  64'(busy),  64'(m_busy));
            chk("valid", 64'(valid), 64'(m_busy && !stall));
            chk("sa",    64'(sa),    64'((m_busy && m_pos < N) ? m_a[m_pos] : 1'b0));
            chk("sb",    64'(sb),    64'((m_busy && m_pos < N) ? m_b[m_pos] : 1'b0));
            chk("first", 64'(first), 64'(m_busy && m_pos == 0 && !stall));
            chk("last",  64'(last),  64'(m_busy && m_pos == 2*N-1 && !stall));
            if (valid === 1'b1 && nbeats < 64) begin
                beat_a[nbeats]     = sa;
                beat_b[nbeats]     = sb;
                first_mask[nbeats] = first;
                last_mask[nbeats]  = last;
                if (nbeats == 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        nbeats = 0; beat_a = '0; beat_b = '0; first_mask = '0; last_mask = '0;
    endtask

    task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid = 1'b1; a_in = a; b_in = b;
    endtask

    task automatic single_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        clear_beats();
        offer(a, b);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk({name, "_a"}, beat_a, {56'd0, a});
        chk({name, "_b"}, beat_b, {56'd0, b});
        chk({name, "_n"}, 64'(nbeats), 64'd16);
        chk({name, "_first"}, first_mask, 64'h0000_0000_0000_0001);
        chk({name, "_last"}, last_mask, 64'h0000_0000_0000_8000);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_outs", {58'd0, valid, sa, sb, first, last, busy}, 64'd0);
        tick();

        // Basic operation: B5 -> 1,0,1,0,1,1,0,1 and 3C -> 0,0,1,1,1,1,0,0.
        single_op("basic", 8'hB5, 8'h3C);
        chk("basic_a_lit", beat_a, 64'h0000_0000_0000_00B5);

        // Back-to-back: second pair taken on the last flush cycle.
        clear_beats();
        offer(8'h5A, 8'hC3);
        tick();
        offer(8'h81, 8'h7E);
        k = 0;
        while (in_ready !== 1'b1 && k < 40) begin tick(); k++; end
        chk("b2b_wait", 64'(k < 40), 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (40) tick();
        chk("b2b_n", 64'(nbeats), 64'd32);
        chk("b2b_span", 64'(last_cyc - first_cyc + 1), 64'd32);
        chk("b2b_a", beat_a, 64'h0000_0000_0081_005A);
        chk("b2b_b", beat_b, 64'h0000_0000_007E_00C3);
        chk("b2b_first", first_mask, 64'h0000_0000_0001_0001);
        chk("b2b_last", last_mask, 64'h0000_0000_8000_8000);

        // Stall for three cycles while bit 4 is on the line.
        clear_beats();
        offer(8'hB5, 8'h3C);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        stall = 1'b1;
        @(negedge clk);
        chk("stall_hold_a", 64'(sa), 64'd1);
        chk("stall_hold_b", 64'(sb), 64'd1);
        tick(); tick(); tick();
        stall = 1'b0;
        repeat (20) tick();
        chk("stall_a", beat_a, 64'h0000_0000_0000_00B5);
        chk("stall_b", beat_b, 64'h0000_0000_0000_003C);
        chk("stall_n", 64'(nbeats), 64'd16);
        chk("stall_span", 64'(last_cyc - first_cyc + 1), 64'd19);

        // Stall on the final flush cycle with the next pair already offered.
        clear_beats();
        offer(8'h33, 8'hCC);
        tick();
        offer(8'h0F, 8'hF0);
        repeat (15) tick();
        stall = 1'b1;
        @(negedge clk);
        chk("stl_last_ready0", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("stl_last_ready1", 64'(in_ready), 64'd0);
        chk("stl_last_busy", 64'(busy), 64'd1);
        tick();
        stall = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("stl_last_n", 64'(nbeats), 64'd32);
        chk("stl_last_span", 64'(last_cyc - first_cyc + 1), 64'd34);
        chk("stl_last_a", beat_a, 64'h0000_0000_000F_0033);
        chk("stl_last_first", first_mask, 64'h0000_0000_0001_0001);

        // Reset mid-SHIFT abandons the operation; a new one starts from bit 0.
        offer(8'hA5, 8'h5A);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(valid), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        #1;
        single_op("mrst_new", 8'h96, 8'h69);

        // Edge values.
        single_op("ones", 8'hFF, 8'hFF);
        single_op("zeros", 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
